// File: rtl/apb_master_engine.sv
// APB master: queued read/write commands run as SETUP/ACCESS transfers (APB_TIMEOUT_EN adds an ACCESS abort).
// Push-to-response is 3 cycles plus one per wait state; cmd_ready = !full; responses cannot be stalled.

module apb_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module apb_master_engine #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                       pclk,
  input  logic                       preset_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [ADDR_W-1:0]          cmd_addr,
  input  logic [DATA_W-1:0]          cmd_wdata,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       busy,
  output logic                       rsp_valid,
  output logic                       rsp_write,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       rsp_timeout,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [ADDR_W-1:0]          paddr,
  output logic [DATA_W-1:0]          pwdata,
  input  logic [DATA_W-1:0]          prdata,
  input  logic                       pready,
  input  logic                       pslverr
);
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state, state_nxt;
  cmd_t   push_cmd, head;
  logic   push, pop, done, abort, full, empty, limit;

  assign push_cmd  = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign busy      = (state != IDLE) || !empty;

  apb_cmd_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
    .clk      (pclk),
    .rst_n    (preset_n),
    .push     (push),
    .push_dat (push_cmd),
    .pop      (pop),
    .head     (head),
    .level    (fifo_level),
    .full     (full),
    .empty    (empty)
  );

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC+1);
  logic [CW-1:0] wait_cnt;

  // limit fires on the edge that would take the count to TIMEOUT_CYC
  assign limit = (wait_cnt == CW'(TIMEOUT_CYC-1));

  always_ff @(posedge pclk) begin
    if (!preset_n)                       wait_cnt <= '0;
    else if (state == SETUP)             wait_cnt <= '0;
    else if (state == ACCESS && !pready) wait_cnt <= wait_cnt + CW'(1);
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) rsp_timeout <= 1'b0;
    else           rsp_timeout <= abort;
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign limit       = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (!preset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (pready) begin
          done = 1'b1;
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end else if (limit) begin
          // abort always passes through IDLE so psel drops for a cycle
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= done || abort;
      rsp_write <= (done || abort) && pwrite;
      rsp_rdata <= (done && !pwrite) ? prdata : '0;
      rsp_err   <= (done && pslverr) || abort;
      if (pop) begin
        psel    <= 1'b1;
        penable <= 1'b0;
        pwrite  <= head.write;
        paddr   <= head.addr;
        pwdata  <= head.write ? head.wdata : '0;
      end else if (state == SETUP) begin
        penable <= 1'b1;
      end else if (done || abort) begin
        psel    <= 1'b0;
        penable <= 1'b0;
        pwrite  <= 1'b0;
        paddr   <= '0;
        pwdata  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_engine.sv
// Bench for apb_master_engine: directed latency/backpressure/reset scenarios plus a randomized run against a queue model.
module tb_apb_master_engine;
  localparam int DEPTH = 4;

  logic       pclk, preset_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic [2:0] fifo_level;
  logic       busy, rsp_valid, rsp_write, rsp_err, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready, pslverr;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
  } mcmd_t;

  apb_master_engine #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .TIMEOUT_CYC(16)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .fifo_level(fifo_level), .busy(busy),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // inputs change at the falling edge, outputs are read at the falling edge
  task automatic step();
    @(negedge pclk);
  endtask

  task automatic push_cmd(input logic w, input logic [7:0] a, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    push_cmd(1'b1, 8'hEE, 8'hEE);
    step(); step();
    n_tests++;
    if ({psel, penable, pwrite, paddr, pwdata} !== 19'd0) begin
      n_fail++; $display("FAIL reset_apb got %b exp 0", {psel, penable, pwrite, paddr, pwdata});
    end
    n_tests++;
    if ({rsp_valid, rsp_write, rsp_rdata, rsp_err, rsp_timeout} !== 12'd0) begin
      n_fail++; $display("FAIL reset_rsp got %b exp 0", {rsp_valid, rsp_write, rsp_rdata, rsp_err, rsp_timeout});
    end
    n_tests++;
    if ({fifo_level, busy, cmd_ready} !== 5'b00001) begin
      n_fail++; $display("FAIL reset_ctl got %b exp 00001", {fifo_level, busy, cmd_ready});
    end
    cmd_valid = 1'b0;
    preset_n  = 1'b1;
    step();
    n_tests++;
    if ({psel, fifo_level, busy} !== 5'd0) begin
      n_fail++; $display("FAIL reset_release got %b exp 0", {psel, fifo_level, busy});
    end
  endtask

  task automatic test_write();
    pready = 1'b1; pslverr = 1'b0;
    push_cmd(1'b1, 8'h10, 8'h3C);
    step();
    cmd_valid = 1'b0;
    n_tests++;
    if ({psel, fifo_level, busy} !== {1'b0, 3'd1, 1'b1}) begin
      n_fail++; $display("FAIL wr_k got %b exp 00011", {psel, fifo_level, busy});
    end
    step();
    n_tests++;
    if ({psel, penable, pwrite, paddr, pwdata, fifo_level} !== {3'b101, 8'h10, 8'h3C, 3'd0}) begin
      n_fail++; $display("FAIL wr_setup got %h/%b/%b a=%h d=%h exp 1/0/1 a=10 d=3c", psel, penable, pwrite, paddr, pwdata);
    end
    step();
    n_tests++;
    if ({psel, penable, rsp_valid, pwdata} !== {3'b110, 8'h3C}) begin
      n_fail++; $display("FAIL wr_access got %b d=%h exp 110 d=3c", {psel, penable, rsp_valid}, pwdata);
    end
    step();
    n_tests++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_timeout, rsp_rdata} !== {4'b1100, 8'h00}) begin
      n_fail++; $display("FAIL wr_rsp got %b rdata=%h exp 1100 rdata=00", {rsp_valid, rsp_write, rsp_err, rsp_timeout}, rsp_rdata);
    end
    n_tests++;
    if ({psel, penable, paddr, pwdata, busy} !== 19'd0) begin
      n_fail++; $display("FAIL wr_idle got %b exp 0", {psel, penable, paddr, pwdata, busy});
    end
    step();
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL wr_pulse rsp_valid got %b exp 0", rsp_valid);
    end
  endtask

  task automatic test_read_wait();
    int acc_cycles;
    pready = 1'b0; pslverr = 1'b1; prdata = 8'h11;
    push_cmd(1'b0, 8'h04, 8'hFF);
    step();
    cmd_valid = 1'b0;
    step();
    n_tests++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {3'b100, 8'h04, 8'h00}) begin
      n_fail++; $display("FAIL rd_setup got %b a=%h d=%h exp 100 a=04 d=00", {psel, penable, pwrite}, paddr, pwdata);
    end
    acc_cycles = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (penable === 1'b1 && rsp_valid === 1'b0) acc_cycles++;
    end
    pready = 1'b1; prdata = 8'hA5; pslverr = 1'b1;
    step();
    acc_cycles++;
    n_tests++;
    if (acc_cycles !== 3) begin
      n_fail++; $display("FAIL rd_wait access cycles got %0d exp 3", acc_cycles);
    end
    n_tests++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_timeout, rsp_rdata} !== {4'b1010, 8'hA5}) begin
      n_fail++; $display("FAIL rd_rsp got %b rdata=%h exp 1010 rdata=a5", {rsp_valid, rsp_write, rsp_err, rsp_timeout}, rsp_rdata);
    end
    pslverr = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    mcmd_t      cmds [3];
    logic [6:0] ps, pe, rv;
    logic [2:0] rw;
    logic [7:0] addrs [$];
    logic [7:0] bad_rdata;
    int         rd_seen;
    cmds[0] = '{1'b1, 8'hA0, 8'h11};
    cmds[1] = '{1'b0, 8'hA1, 8'h00};
    cmds[2] = '{1'b1, 8'hA2, 8'h22};
    pready = 1'b1; pslverr = 1'b0; prdata = 8'h5A;
    ps = '0; pe = '0; rv = '0; rw = '0; rd_seen = 0; bad_rdata = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) push_cmd(cmds[i].w, cmds[i].a, cmds[i].d);
      else cmd_valid = 1'b0;
      step();
      if (i >= 1) begin
        ps = {ps[5:0], psel};
        pe = {pe[5:0], penable};
        rv = {rv[5:0], rsp_valid};
        if (rsp_valid === 1'b1) rw = {rw[1:0], rsp_write};
        if (rsp_valid === 1'b1 && rsp_write === 1'b0) begin
          rd_seen++;
          bad_rdata = rsp_rdata;
        end
        if (psel === 1'b1 && penable === 1'b0) addrs.push_back(paddr);
      end
    end
    n_tests++;
    if (ps !== 7'b1111110) begin n_fail++; $display("FAIL b2b_psel got %b exp 1111110", ps); end
    n_tests++;
    if (pe !== 7'b0101010) begin n_fail++; $display("FAIL b2b_penable got %b exp 0101010", pe); end
    n_tests++;
    if (rv !== 7'b0010101) begin n_fail++; $display("FAIL b2b_rsp_valid got %b exp 0010101", rv); end
    n_tests++;
    if (rw !== 3'b101) begin n_fail++; $display("FAIL b2b_order rsp_write got %b exp 101", rw); end
    n_tests++;
    if (addrs.size() !== 3 || addrs[0] !== 8'hA0 || addrs[1] !== 8'hA1 || addrs[2] !== 8'hA2) begin
      n_fail++; $display("FAIL b2b_addr got %0d setups first=%h exp 3 setups a0,a1,a2", addrs.size(), (addrs.size() > 0) ? addrs[0] : 8'h00);
    end
    n_tests++;
    if (rd_seen !== 1 || bad_rdata !== 8'h5A) begin
      n_fail++; $display("FAIL b2b_rdata got %0d reads rdata=%h exp 1 read rdata=5a", rd_seen, bad_rdata);
    end
  endtask

  task automatic test_full();
    int rsp_cnt;
    int cyc;
    pready = 1'b0; pslverr = 1'b0; prdata = 8'h00;
    for (int i = 0; i < 5; i++) begin
      push_cmd(1'b1, 8'(i), 8'(i + 8'h30));
      step();
    end
    push_cmd(1'b1, 8'h55, 8'h55);
    n_tests++;
    if ({cmd_ready, fifo_level} !== {1'b0, 3'd4}) begin
      n_fail++; $display("FAIL full_level got ready=%b level=%0d exp ready=0 level=4", cmd_ready, fifo_level);
    end
    step();
    n_tests++;
    if ({cmd_ready, fifo_level, penable} !== {1'b0, 3'd4, 1'b1}) begin
      n_fail++; $display("FAIL full_block got ready=%b level=%0d en=%b exp ready=0 level=4 en=1", cmd_ready, fifo_level, penable);
    end
    cmd_valid = 1'b0; pready = 1'b1;
    step();
    n_tests++;
    if ({cmd_ready, fifo_level, rsp_valid, psel, penable, paddr} !== {1'b1, 3'd3, 3'b110, 8'h01}) begin
      n_fail++; $display("FAIL full_release got ready=%b level=%0d rsp=%b a=%h exp ready=1 level=3 rsp=1 a=01", cmd_ready, fifo_level, rsp_valid, paddr);
    end
    rsp_cnt = (rsp_valid === 1'b1) ? 1 : 0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      step();
      if (rsp_valid === 1'b1) rsp_cnt++;
      cyc++;
    end
    n_tests++;
    if (rsp_cnt !== 5 || busy !== 1'b0) begin
      n_fail++; $display("FAIL full_drain got %0d responses busy=%b exp 5 responses busy=0", rsp_cnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    pready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_cmd(1'b0, 8'(8'h60 + i), 8'h00);
      step();
    end
    cmd_valid = 1'b0;
    step();
    n_tests++;
    if ({psel, penable, fifo_level} !== {2'b11, 3'd2}) begin
      n_fail++; $display("FAIL rstmid_pre got %b exp 11010", {psel, penable, fifo_level});
    end
    preset_n = 1'b0;
    step();
    n_tests++;
    if ({psel, penable, fifo_level, busy, rsp_valid} !== 7'd0) begin
      n_fail++; $display("FAIL rstmid_flush got %b exp 0", {psel, penable, fifo_level, busy, rsp_valid});
    end
    preset_n = 1'b1; pready = 1'b1;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp_valid !== 1'b0 || psel !== 1'b0) stray++;
    end
    n_tests++;
    if (stray !== 0) begin n_fail++; $display("FAIL rstmid_stray got %0d active cycles exp 0", stray); end
    push_cmd(1'b1, 8'h77, 8'h99);
    step();
    cmd_valid = 1'b0;
    step();
    n_tests++;
    if ({psel, penable, paddr, pwdata} !== {2'b10, 8'h77, 8'h99}) begin
      n_fail++; $display("FAIL rstmid_setup got %b a=%h d=%h exp 10 a=77 d=99", {psel, penable}, paddr, pwdata);
    end
    step(); step();
    n_tests++;
    if ({rsp_valid, rsp_write, rsp_err} !== 3'b110) begin
      n_fail++; $display("FAIL rstmid_rsp got %b exp 110", {rsp_valid, rsp_write, rsp_err});
    end
    step();
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    int bad;
    pready = 1'b0; pslverr = 1'b1; prdata = 8'hC3;
    push_cmd(1'b0, 8'h40, 8'h00);
    step();
    push_cmd(1'b1, 8'h41, 8'h42);
    step();
    cmd_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (penable !== 1'b1 || rsp_valid !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL tmo_wait got %0d early-end cycles exp 0", bad); end
    step();
    n_tests++;
    if ({psel, penable, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {5'b00111, 8'h00}) begin
      n_fail++; $display("FAIL tmo_abort got %b rdata=%h exp 00111 rdata=00", {psel, penable, rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
    end
    step();
    n_tests++;
    if ({psel, penable, paddr, rsp_valid} !== {2'b10, 8'h41, 1'b0}) begin
      n_fail++; $display("FAIL tmo_next got %b a=%h exp 10 a=41", {psel, penable}, paddr);
    end
    pready = 1'b1; pslverr = 1'b0;
    step(); step();
    n_tests++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_timeout} !== 4'b1100) begin
      n_fail++; $display("FAIL tmo_normal got %b exp 1100", {rsp_valid, rsp_write, rsp_err, rsp_timeout});
    end
    step();
  endtask
`endif

  task automatic test_random();
    mcmd_t      q [$];
    mcmd_t      cur, nc;
    int         ph;
    int         wait_left;
    logic       do_push, complete;
    logic       e_rv, e_rw, e_err;
    logic [7:0] e_rdata;
    logic       e_pw;
    logic [7:0] e_pa, e_pd;
    ph = 0; wait_left = 0; cur = '0;
    for (int c = 0; c < 400; c++) begin
      cmd_valid = (c < 300) && ($urandom_range(0, 2) != 0);
      cmd_write = 1'($urandom);
      cmd_addr  = 8'($urandom);
      cmd_wdata = 8'($urandom);
      prdata    = 8'($urandom);
      pslverr   = 1'($urandom);
      pready    = (ph == 2) ? (wait_left == 0) : 1'($urandom);

      // expected state after the coming edge
      do_push  = cmd_valid && (q.size() < DEPTH);
      nc       = '{cmd_write, cmd_addr, cmd_wdata};
      complete = (ph == 2) && pready;
      e_rv     = complete;
      e_rw     = complete && cur.w;
      e_rdata  = (complete && !cur.w) ? prdata : 8'h00;
      e_err    = complete && pslverr;
      if (ph == 1) begin
        ph = 2;
        wait_left = $urandom_range(0, 3);
      end else if (ph == 0 || complete) begin
        if (q.size() > 0) begin
          cur = q.pop_front();
          ph  = 1;
        end else begin
          ph = 0;
        end
      end else begin
        wait_left--;
      end
      if (do_push) q.push_back(nc);
      e_pw = (ph != 0) && cur.w;
      e_pa = (ph != 0) ? cur.a : 8'h00;
      e_pd = (ph != 0 && cur.w) ? cur.d : 8'h00;

      step();
      n_tests++;
      if ({psel, penable} !== {ph != 0, ph == 2}) begin
        n_fail++; $display("FAIL rnd_phase cyc %0d got %b exp %b", c, {psel, penable}, {ph != 0, ph == 2});
      end
      n_tests++;
      if ({pwrite, paddr, pwdata} !== {e_pw, e_pa, e_pd}) begin
        n_fail++; $display("FAIL rnd_bus cyc %0d got w=%b a=%h d=%h exp w=%b a=%h d=%h", c, pwrite, paddr, pwdata, e_pw, e_pa, e_pd);
      end
      n_tests++;
      if ({rsp_valid, rsp_write, rsp_rdata, rsp_err, rsp_timeout} !== {e_rv, e_rw, e_rdata, e_err, 1'b0}) begin
        n_fail++; $display("FAIL rnd_rsp cyc %0d got v=%b w=%b r=%h e=%b t=%b exp v=%b w=%b r=%h e=%b t=0",
                           c, rsp_valid, rsp_write, rsp_rdata, rsp_err, rsp_timeout, e_rv, e_rw, e_rdata, e_err);
      end
      n_tests++;
      if ({fifo_level, cmd_ready, busy} !== {3'(q.size()), q.size() < DEPTH, (ph != 0) || (q.size() != 0)}) begin
        n_fail++; $display("FAIL rnd_ctl cyc %0d got lvl=%0d rdy=%b busy=%b exp lvl=%0d", c, fifo_level, cmd_ready, busy, q.size());
      end
    end
    cmd_valid = 1'b0; pready = 1'b0; pslverr = 1'b0;
  endtask

  initial begin
    preset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    prdata = 8'h00; pready = 1'b0; pslverr = 1'b0;
    step();
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_full();
    test_reset_mid();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
